// File: rtl/dna_score_pkg.sv
// Shared types and widths for the DNA alignment score engine.
package dna_score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RUN,
        DRAIN,
        EMIT
    } state_e;

    localparam int NT_PER_WORD = 16;
    localparam int WSCORE_W    = 22;
    localparam int ACC_W       = 32;

    function automatic logic [4:0] count_matches(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] m;
        m = 5'd0;
        for (int i = 0; i < NT_PER_WORD; i++) begin
            if (a[2*i +: 2] == b[2*i +: 2]) m = m + 5'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/dna_word_scorer.sv
// Registered per-word score: matches * reward - mismatches * penalty, 22-bit signed.
// One cycle latency from en_i; no backpressure (result held until next en_i).
module dna_word_scorer
    import dna_score_pkg::*;
#(
    parameter logic [15:0] MATCH_SCORE      = 16'd2,
    parameter logic [15:0] MISMATCH_PENALTY = 16'd1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [31:0]                x_i,
    input  logic [31:0]                y_i,
    output logic signed [WSCORE_W-1:0] score_o
);

    logic [4:0]                 m_w;
    logic [WSCORE_W-1:0]        pos_w;
    logic [WSCORE_W-1:0]        neg_w;
    logic signed [WSCORE_W-1:0] score_d;
    logic signed [WSCORE_W-1:0] score_q;

    assign m_w   = count_matches(x_i, y_i);
    assign pos_w = WSCORE_W'(m_w) * WSCORE_W'(MATCH_SCORE);
    assign neg_w = WSCORE_W'(5'd16 - m_w) * WSCORE_W'(MISMATCH_PENALTY);
    // Worst case 16 * 65535 still fits, so the 22-bit difference is exact.
    assign score_d = $signed(pos_w - neg_w);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            score_q <= '0;
        end else if (en_i) begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/dna_score_engine.sv
// Streams word pairs from dna_x/dna_y FIFOs, sums per-word alignment scores, writes one signed total.
// Accumulator lags the read strobe by 3 cycles; one word pair per cycle while both FIFOs hold data.
// Stalls on empty inputs and on score_full; DNA_SCORE_SATURATE_EN clamps the total instead of wrapping.
module dna_score_engine
    import dna_score_pkg::*;
#(
    parameter logic [15:0] MATCH_SCORE      = 16'd2,
    parameter logic [15:0] MISMATCH_PENALTY = 16'd1
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic [31:0] x_dout,
    input  logic        x_empty,
    output logic        x_rd_en,
    input  logic        x_open,
    input  logic [31:0] y_dout,
    input  logic        y_empty,
    output logic        y_rd_en,
    input  logic        y_open,
    output logic [31:0] score_din,
    output logic        score_wr_en,
    input  logic        score_full,
    output logic        score_eof,
    output logic        busy,
    output logic        abort
);

    state_e                     state_q;
    logic                       hdr_rd_q;
    logic [15:0]                len_q;
    logic [15:0]                issued_q;
    logic                       rd_v_q;
    logic                       sc_v_q;
    logic [ACC_W-1:0]           acc_q;
    logic [ACC_W-1:0]           acc_d;
    logic                       abort_q;
    logic                       eof_q;
    logic signed [WSCORE_W-1:0] wscore;
    logic [ACC_W-1:0]           wscore_ext;
    logic                       both_open;
    logic                       hdr_rd;
    logic                       run_rd;

    assign both_open = x_open & y_open;
    assign hdr_rd    = (state_q == HDR) && !hdr_rd_q && both_open;
    assign run_rd    = (state_q == RUN) && both_open && !x_empty && !y_empty
                       && (issued_q != len_q);

    assign x_rd_en     = hdr_rd | run_rd;
    assign y_rd_en     = run_rd;
    assign score_wr_en = (state_q == EMIT) && !score_full;
    assign score_din   = acc_q;
    assign score_eof   = eof_q;
    assign busy        = (state_q != IDLE);
    assign abort       = abort_q;

    dna_word_scorer #(
        .MATCH_SCORE      (MATCH_SCORE),
        .MISMATCH_PENALTY (MISMATCH_PENALTY)
    ) u_scorer (
        .clk_i   (bus_clk),
        .rst_i   (bus_rst),
        .en_i    (rd_v_q),
        .x_i     (x_dout),
        .y_i     (y_dout),
        .score_o (wscore)
    );

    assign wscore_ext = {{(ACC_W-WSCORE_W){wscore[WSCORE_W-1]}}, wscore};

`ifdef DNA_SCORE_SATURATE_EN
    logic [ACC_W:0] sum_w;

    assign sum_w = {acc_q[ACC_W-1], acc_q} + {wscore_ext[ACC_W-1], wscore_ext};

    // Sign bits disagree only on overflow; clamp toward the overflow direction.
    always_comb begin
        acc_d = sum_w[ACC_W-1:0];
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            acc_d = sum_w[ACC_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    assign acc_d = acc_q + wscore_ext;
`endif

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q  <= IDLE;
            hdr_rd_q <= 1'b0;
            len_q    <= '0;
            issued_q <= '0;
            rd_v_q   <= 1'b0;
            sc_v_q   <= 1'b0;
            acc_q    <= '0;
            abort_q  <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            eof_q  <= (state_q == IDLE) && !x_open && x_empty;
            rd_v_q <= run_rd;
            sc_v_q <= rd_v_q;
            if (sc_v_q) acc_q <= acc_d;

            case (state_q)
                IDLE: begin
                    if (x_open && !x_empty) begin
                        state_q  <= HDR;
                        hdr_rd_q <= 1'b0;
                    end
                end
                HDR: begin
                    if (!both_open) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                        rd_v_q  <= 1'b0;
                        sc_v_q  <= 1'b0;
                    end else if (!hdr_rd_q) begin
                        hdr_rd_q <= 1'b1;
                    end else begin
                        len_q    <= x_dout[15:0];
                        issued_q <= '0;
                        acc_q    <= '0;
                        abort_q  <= 1'b0;
                        state_q  <= (x_dout[15:0] == 16'd0) ? EMIT : RUN;
                    end
                end
                RUN: begin
                    if (!both_open) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                        rd_v_q  <= 1'b0;
                        sc_v_q  <= 1'b0;
                    end else if (run_rd) begin
                        issued_q <= issued_q + 16'd1;
                        if (issued_q + 16'd1 == len_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!both_open) begin
                        state_q <= IDLE;
                        abort_q <= 1'b1;
                        rd_v_q  <= 1'b0;
                        sc_v_q  <= 1'b0;
                    end else if (!rd_v_q && !sc_v_q) begin
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (!score_full) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dna_score_engine.sv
// Directed and randomized jobs against FIFO models and a per-nucleotide scoring model.
module tb_dna_score_engine;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic [31:0] x_dout = '0, y_dout = '0, score_din;
    logic        x_empty, y_empty, x_rd_en, y_rd_en;
    logic        x_open = 1'b0, y_open = 1'b0;
    logic        score_wr_en, score_full = 1'b0, score_eof, busy, abort;

    logic [31:0] x2_dout = '0;
    logic [31:0] y2_dout = '0;
    logic        x2_empty, x2_rd_en, y2_rd_en;
    logic        y2_empty = 1'b0;
    logic        x2_open = 1'b0, y2_open = 1'b0;
    logic [31:0] score2_din;
    logic        score2_wr_en, score2_eof, busy2, abort2;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] x_mem [0:255];
    logic [31:0] y_mem [0:255];
    int x_wr = 0, x_rd = 0, y_wr = 0, y_rd = 0;
    int x2_rd = 0, x2_avail = 0;
    logic x_pop_s = 1'b0, y_pop_s = 1'b0, x2_pop_s = 1'b0;

    logic [31:0] wr_dat [0:63];
    int wr_cnt = 0, full_wr = 0, underflow = 0, sep_err = 0, cyc = 0, ypops = 0;
    int ypop_cyc [0:511];
    logic [31:0] wr2_dat = '0;
    int wr2_cnt = 0;

    assign x_empty  = (x_rd == x_wr);
    assign y_empty  = (y_rd == y_wr);
    assign x2_empty = (x2_rd == x2_avail);

    always #5 bus_clk = ~bus_clk;

    dna_score_engine u_dut (
        .bus_clk     (bus_clk),
        .bus_rst     (bus_rst),
        .x_dout      (x_dout),
        .x_empty     (x_empty),
        .x_rd_en     (x_rd_en),
        .x_open      (x_open),
        .y_dout      (y_dout),
        .y_empty     (y_empty),
        .y_rd_en     (y_rd_en),
        .y_open      (y_open),
        .score_din   (score_din),
        .score_wr_en (score_wr_en),
        .score_full  (score_full),
        .score_eof   (score_eof),
        .busy        (busy),
        .abort       (abort)
    );

    dna_score_engine #(
        .MATCH_SCORE      (16'd65535),
        .MISMATCH_PENALTY (16'd1)
    ) u_big (
        .bus_clk     (bus_clk),
        .bus_rst     (bus_rst),
        .x_dout      (x2_dout),
        .x_empty     (x2_empty),
        .x_rd_en     (x2_rd_en),
        .x_open      (x2_open),
        .y_dout      (y2_dout),
        .y_empty     (y2_empty),
        .y_rd_en     (y2_rd_en),
        .y_open      (y2_open),
        .score_din   (score2_din),
        .score_wr_en (score2_wr_en),
        .score_full  (1'b0),
        .score_eof   (score2_eof),
        .busy        (busy2),
        .abort       (abort2)
    );

    // Monitors sample mid-cycle; FIFO models act on the following rising edge.
    always @(negedge bus_clk) begin
        cyc++;
        x_pop_s  = x_rd_en;
        y_pop_s  = y_rd_en;
        x2_pop_s = x2_rd_en;
        if (x_rd_en && x_empty) underflow++;
        if (y_rd_en && y_empty) underflow++;
        if (y_rd_en != x_rd_en && !(x_rd_en && busy && !y_rd_en && x_rd < 0)) begin
            if (y_rd_en) sep_err++;
        end
        if (y_rd_en) begin
            ypop_cyc[ypops] = cyc;
            ypops++;
        end
        if (score_wr_en) begin
            wr_dat[wr_cnt] = score_din;
            wr_cnt++;
            if (score_full) full_wr++;
        end
        if (score2_wr_en) begin
            wr2_dat = score2_din;
            wr2_cnt++;
        end
    end

    always @(posedge bus_clk) begin
        if (x_pop_s && x_rd != x_wr) begin
            x_dout <= x_mem[x_rd];
            x_rd   <= x_rd + 1;
        end
        if (y_pop_s && y_rd != y_wr) begin
            y_dout <= y_mem[y_rd];
            y_rd   <= y_rd + 1;
        end
        if (x2_pop_s && x2_rd != x2_avail) begin
            x2_dout <= (x2_rd == 0) ? 32'h0000_FFFF : 32'h0;
            x2_rd   <= x2_rd + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge bus_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_x(input logic [31:0] w);
        x_mem[x_wr] = w;
        x_wr++;
    endtask

    task automatic push_y(input logic [31:0] w);
        y_mem[y_wr] = w;
        y_wr++;
    endtask

    task automatic wait_wr(input int target, input string tag);
        int n = 0;
        while (wr_cnt < target && n < 300) begin
            tick(1);
            n++;
        end
        check({tag, "_write_seen"}, 32'(wr_cnt), 32'(target));
    endtask

    function automatic longint word_score(input logic [31:0] a, input logic [31:0] b,
                                          input longint ms, input longint mp);
        int m = 0;
        for (int i = 0; i < 16; i++) if (a[2*i +: 2] == b[2*i +: 2]) m++;
        return longint'(m) * ms - longint'(16 - m) * mp;
    endfunction

    function automatic longint acc_rule(input longint acc, input longint s);
        longint t = acc + s;
`ifdef DNA_SCORE_SATURATE_EN
        if (t > 64'sd2147483647) t = 64'sd2147483647;
        if (t < -64'sd2147483648) t = -64'sd2147483648;
`else
        t = longint'(int'(t));
`endif
        return t;
    endfunction

    initial begin
        logic [31:0] xs [0:7];
        logic [31:0] ys [0:7];
        longint      exp_acc;
        int          len, base, wr_before;

        // Reset state
        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_eof", 32'(score_eof), 32'd0);
        check("rst_wr_en", 32'(score_wr_en), 32'd0);
        check("rst_score_din", score_din, 32'd0);
        check("rst_x_rd_en", 32'(x_rd_en), 32'd0);
        bus_rst = 1'b0;
        tick(2);
        check("eof_closed_empty", 32'(score_eof), 32'd1);
        x_open = 1'b1;
        y_open = 1'b1;
        tick(2);
        check("eof_open", 32'(score_eof), 32'd0);

        // L=1 all match
        push_x(32'd1); push_x(32'h0); push_y(32'h0);
        wait_wr(1, "match1");
        check("match1_score", wr_dat[0], 32'd32);
        check("match1_idle", 32'(busy), 32'd0);

        // L=1 all mismatch
        push_x(32'd1); push_x(32'h0); push_y(32'h5555_5555);
        wait_wr(2, "mism1");
        check("mism1_score", wr_dat[1], 32'hFFFF_FFF0);

        // L=0 header: score 0 and dna_y untouched
        base = ypops;
        push_x(32'd0);
        wait_wr(3, "len0");
        check("len0_score", wr_dat[2], 32'd0);
        check("len0_no_y_reads", 32'(ypops), 32'(base));

        // Score FIFO full while the total is ready
        score_full = 1'b1;
        push_x(32'd2); push_x(32'h0); push_x(32'hFFFF_FFFF);
        push_y(32'h0); push_y(32'hFFFF_FFFF);
        tick(25);
        check("full_no_write", 32'(wr_cnt), 32'd3);
        check("full_busy_held", 32'(busy), 32'd1);
        check("full_wr_en_low", 32'(score_wr_en), 32'd0);
        score_full = 1'b0;
        wait_wr(4, "full");
        check("full_score", wr_dat[3], 32'd64);
        tick(5);
        check("full_single_write", 32'(wr_cnt), 32'd4);

        // Randomized jobs with throughput check
        for (int j = 0; j < 6; j++) begin
            len     = $urandom_range(1, 8);
            exp_acc = 0;
            base    = ypops;
            wr_before = wr_cnt;
            push_x(32'(len));
            for (int k = 0; k < len; k++) begin
                xs[k] = $urandom();
                ys[k] = xs[k] ^ ($urandom() & $urandom());
                push_x(xs[k]);
                push_y(ys[k]);
                exp_acc = acc_rule(exp_acc, word_score(xs[k], ys[k], 2, 1));
            end
            wait_wr(wr_before + 1, $sformatf("rnd%0d", j));
            check($sformatf("rnd%0d_score", j), wr_dat[wr_before], 32'(exp_acc));
            check($sformatf("rnd%0d_y_reads", j), 32'(ypops - base), 32'(len));
            check($sformatf("rnd%0d_throughput", j),
                  32'(ypop_cyc[base + len - 1] - ypop_cyc[base]), 32'(len - 1));
        end

        // y_open drops mid-job after three word reads
        wr_before = wr_cnt;
        push_x(32'd5);
        for (int k = 0; k < 3; k++) begin
            push_x(32'h0);
            push_y(32'h0);
        end
        tick(15);
        check("abort_run_busy", 32'(busy), 32'd1);
        y_open = 1'b0;
        tick(3);
        check("abort_flag", 32'(abort), 32'd1);
        check("abort_idle", 32'(busy), 32'd0);
        tick(10);
        check("abort_no_write", 32'(wr_cnt), 32'(wr_before));
        y_open = 1'b1;
        push_x(32'd1); push_x(32'h0); push_y(32'h0);
        wait_wr(wr_before + 1, "after_abort");
        check("after_abort_score", wr_dat[wr_before], 32'd32);
        check("after_abort_flag", 32'(abort), 32'd0);

        // Reset mid-job
        wr_before = wr_cnt;
        push_x(32'd4);
        push_x(32'h1234_5678); push_x(32'h0);
        push_y(32'h1234_5678); push_y(32'h0);
        tick(12);
        check("midrst_busy_before", 32'(busy), 32'd1);
        bus_rst = 1'b1;
        tick(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_score_din", score_din, 32'd0);
        check("midrst_x_rd_en", 32'(x_rd_en), 32'd0);
        bus_rst = 1'b0;
        tick(10);
        check("midrst_no_write", 32'(wr_cnt), 32'(wr_before));

        check("no_underflow", 32'(underflow), 32'd0);
        check("no_lone_y_strobe", 32'(sep_err), 32'd0);
        check("no_write_while_full", 32'(full_wr), 32'd0);

        // Maximum reward, maximum length
        exp_acc = 0;
        for (int k = 0; k < 65535; k++) exp_acc = acc_rule(exp_acc, 64'sd16 * 64'sd65535);
        x2_open  = 1'b1;
        y2_open  = 1'b1;
        x2_avail = 65536;
        begin
            int n = 0;
            while (wr2_cnt == 0 && n < 70000) begin
                tick(1);
                n++;
            end
        end
        check("big_write_seen", 32'(wr2_cnt), 32'd1);
        check("big_score", wr2_dat, 32'(exp_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
